// File: rtl/lc2k_fetch_stage_if.sv
// Fetch-stage bus: inputs from memory/hazard logic, outputs to memory address and IF/ID.
// master = the fetch stage itself, slave = memory/decode/hazard side.
interface lc2k_fetch_stage_if;
    logic [31:0] instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] pcCurrent;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPcPlus1;
    logic        ifidValid;
    logic        halted;
    logic        fetchFault;

    modport master (
        input  instr, stall, redirect, redirectPc,
        output pcCurrent, ifidInstr, ifidPcPlus1, ifidValid, halted, fetchFault
    );

    modport slave (
        output instr, stall, redirect, redirectPc,
        input  pcCurrent, ifidInstr, ifidPcPlus1, ifidValid, halted, fetchFault
    );
endinterface

// File: rtl/lc2k_fetch_stage.sv
// LC2K instruction fetch: owns PC, registers instr into IF/ID, latency 1, one fetch per cycle.
// Stall holds PC and IF/ID; redirect overrides stall and flushes IF/ID with a noop bubble.
module lc2k_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IMEM_DEPTH = 12,
    parameter logic [31:0] NOOP_WORD  = 32'd29360128
) (
    input  logic                 clk,
    input  logic                 reset,
    lc2k_fetch_stage_if.master   bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_pcp1_q;
    logic        ifid_valid_q;

    logic        pc_oob;
    logic        is_halt;
    logic [31:0] pc_plus1;

    assign pc_plus1 = pc_q + 32'd1;
    assign pc_oob   = (pc_q >= IMEM_DEPTH);
    assign is_halt  = (bus.instr[24:22] == 3'b110);

    // Priority: redirect, then stall, then the per-state fetch action.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOOP_WORD;
            ifid_pcp1_q  <= 32'd0;
            ifid_valid_q <= 1'b0;
            state_q      <= RUN;
        end else if (bus.redirect) begin
            pc_q         <= bus.redirectPc;
            ifid_instr_q <= NOOP_WORD;
            ifid_pcp1_q  <= 32'd0;
            ifid_valid_q <= 1'b0;
            state_q      <= RUN;
        end else if (!bus.stall) begin
            case (state_q)
                RUN: begin
                    if (pc_oob) begin
                        ifid_instr_q <= NOOP_WORD;
                        ifid_pcp1_q  <= 32'd0;
                        ifid_valid_q <= 1'b0;
                        state_q      <= FAULT;
                    end else begin
                        ifid_instr_q <= bus.instr;
                        ifid_pcp1_q  <= pc_plus1;
                        ifid_valid_q <= 1'b1;
                        // Halt is committed to IF/ID but PC freezes on it.
                        if (is_halt) begin
                            state_q <= HALTED;
                        end else begin
                            pc_q <= pc_plus1;
                        end
                    end
                end
                default: begin
                    ifid_instr_q <= NOOP_WORD;
                    ifid_pcp1_q  <= 32'd0;
                    ifid_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pcCurrent   = pc_q;
    assign bus.ifidInstr   = ifid_instr_q;
    assign bus.ifidPcPlus1 = ifid_pcp1_q;
    assign bus.ifidValid   = ifid_valid_q;
    assign bus.halted      = (state_q == HALTED);
    assign bus.fetchFault  = (state_q == FAULT);

endmodule

// File: tb/tb_lc2k_fetch_stage.sv
// Bench for lc2k_fetch_stage: scripted stimulus rows with expected outputs queued and checked per edge.
module tb_lc2k_fetch_stage;

    localparam logic [31:0] NOOP = 32'd29360128;
    localparam logic [31:0] HALT = 32'd25165824;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp1;
        logic        valid;
        logic        halted;
        logic        fault;
    } obs_t;

    typedef struct packed {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
    } stim_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    obs_t  sb[$];
    stim_t stq[$];

    lc2k_fetch_stage_if bus ();

    lc2k_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memw(input logic [31:0] a);
        case (a)
            32'd0:   memw = 32'd8454158;
            32'd1:   memw = 32'd8519693;
            32'd2:   memw = 32'd8585228;
            32'd11:  memw = HALT;
            default: memw = (32'd2 << 22) | (a << 8) | a;
        endcase
    endfunction

    always_comb begin
        if (bus.pcCurrent < 32'd12) bus.instr = memw(bus.pcCurrent);
        else                        bus.instr = 32'hDEAD_BEEF;
    end

    function automatic obs_t observe();
        observe = {bus.pcCurrent, bus.ifidInstr, bus.ifidPcPlus1,
                   bus.ifidValid, bus.halted, bus.fetchFault};
    endfunction

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] p1,
                       input logic v, input logic h, input logic f);
        stq.push_back('{stall: st, redir: rd, rpc: rpc});
        sb.push_back('{pc: pc, instr: ins, pcp1: p1, valid: v, halted: h, fault: f});
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t e;
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirectPc = 32'd0;
        #1 reset = 1'b1;
        #1;
        e = '{pc: 32'd0, instr: NOOP, pcp1: 32'd0, valid: 1'b0, halted: 1'b0, fault: 1'b0};
        got = observe();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", got, e);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_run();
        stim_t s; obs_t got; obs_t e; int n = 0;
        add(0, 0, 0, 1, memw(0), 1, 1, 0, 0);
        add(0, 0, 0, 2, memw(1), 2, 1, 0, 0);
        add(0, 0, 0, 3, memw(2), 3, 1, 0, 0);
        add(0, 0, 0, 4, memw(3), 4, 1, 0, 0);
        while (stq.size() > 0) begin
            s = stq.pop_front();
            bus.stall = s.stall; bus.redirect = s.redir; bus.redirectPc = s.rpc;
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL run step %0d got %h expected %h", n, got, e);
            end
            n++;
        end
    endtask

    task automatic test_stall();
        stim_t s; obs_t got; obs_t e; int n = 0;
        add(1, 0, 0, 4, memw(3), 4, 1, 0, 0);
        add(1, 0, 0, 4, memw(3), 4, 1, 0, 0);
        add(0, 0, 0, 5, memw(4), 5, 1, 0, 0);
        add(0, 0, 0, 6, memw(5), 6, 1, 0, 0);
        add(0, 0, 0, 7, memw(6), 7, 1, 0, 0);
        while (stq.size() > 0) begin
            s = stq.pop_front();
            bus.stall = s.stall; bus.redirect = s.redir; bus.redirectPc = s.rpc;
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL stall step %0d got %h expected %h", n, got, e);
            end
            n++;
        end
    endtask

    task automatic test_redirect();
        stim_t s; obs_t got; obs_t e; int n = 0;
        add(1, 1, 1, 1, NOOP, 0, 0, 0, 0);
        add(0, 0, 0, 2, memw(1), 2, 1, 0, 0);
        while (stq.size() > 0) begin
            s = stq.pop_front();
            bus.stall = s.stall; bus.redirect = s.redir; bus.redirectPc = s.rpc;
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL redirect step %0d got %h expected %h", n, got, e);
            end
            n++;
        end
    endtask

    task automatic test_halt();
        stim_t s; obs_t got; obs_t e; int n = 0;
        add(0, 1, 11, 11, NOOP, 0, 0, 0, 0);
        add(1, 0, 0, 11, NOOP, 0, 0, 0, 0);
        add(0, 0, 0, 11, HALT, 12, 1, 1, 0);
        add(0, 0, 0, 11, NOOP, 0, 0, 1, 0);
        add(1, 0, 0, 11, NOOP, 0, 0, 1, 0);
        add(0, 0, 0, 11, NOOP, 0, 0, 1, 0);
        add(0, 1, 0, 0, NOOP, 0, 0, 0, 0);
        add(0, 0, 0, 1, memw(0), 1, 1, 0, 0);
        while (stq.size() > 0) begin
            s = stq.pop_front();
            bus.stall = s.stall; bus.redirect = s.redir; bus.redirectPc = s.rpc;
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL halt step %0d got %h expected %h", n, got, e);
            end
            n++;
        end
    endtask

    task automatic test_fault();
        stim_t s; obs_t got; obs_t e; int n = 0;
        add(0, 1, 12, 12, NOOP, 0, 0, 0, 0);
        add(1, 0, 0, 12, NOOP, 0, 0, 0, 0);
        add(0, 0, 0, 12, NOOP, 0, 0, 0, 1);
        add(0, 0, 0, 12, NOOP, 0, 0, 0, 1);
        add(0, 1, 0, 0, NOOP, 0, 0, 0, 0);
        add(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NOOP, 0, 0, 0, 0);
        add(0, 0, 0, 32'hFFFF_FFFF, NOOP, 0, 0, 0, 1);
        add(0, 1, 10, 10, NOOP, 0, 0, 0, 0);
        add(0, 0, 0, 11, memw(10), 11, 1, 0, 0);
        add(0, 1, 0, 0, NOOP, 0, 0, 0, 0);
        while (stq.size() > 0) begin
            s = stq.pop_front();
            bus.stall = s.stall; bus.redirect = s.redir; bus.redirectPc = s.rpc;
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL fault step %0d got %h expected %h", n, got, e);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s; obs_t got; obs_t e; int n = 0;
        for (int i = 0; i < 11; i++) begin
            add(0, 0, 0, 32'(i + 1), memw(32'(i)), 32'(i + 1), 1, 0, 0);
        end
        add(0, 0, 0, 11, HALT, 12, 1, 1, 0);
        while (stq.size() > 0) begin
            s = stq.pop_front();
            bus.stall = s.stall; bus.redirect = s.redir; bus.redirectPc = s.rpc;
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back step %0d got %h expected %h", n, got, e);
            end
            n++;
        end
    endtask

    task automatic test_async_reset();
        obs_t got;
        obs_t e;
        e = '{pc: 32'd0, instr: NOOP, pcp1: 32'd0, valid: 1'b0, halted: 1'b0, fault: 1'b0};
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        got = observe();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL async_reset_midcycle got %h expected %h", got, e);
        end
        @(posedge clk); #1;
        got = observe();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL async_reset_held got %h expected %h", got, e);
        end
        @(negedge clk);
        reset = 1'b0;
        e = '{pc: 32'd1, instr: memw(0), pcp1: 32'd1, valid: 1'b1, halted: 1'b0, fault: 1'b0};
        @(posedge clk); #1;
        got = observe();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL after_reset_fetch got %h expected %h", got, e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
